// File: rtl/switch_pkg.sv
// Shared constants and types for the switch debouncer.
// Counter width is derived from the stability window so the counter never needs to wrap.
package switch_pkg;

   localparam int WIDTH_DEF         = 6;
   localparam int STABLE_CYCLES_DEF = 20000;

   typedef enum logic {
      STEADY  = 1'b0,
      PENDING = 1'b1
   } state_t;

   // Bits needed to hold n-1; at least one bit so n=1 still has a counter
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(STABLE_CYCLES_DEF);

endpackage

// File: rtl/switch_debouncer_channel.sv
// One switch bit: two-flop synchroniser, stability counter FSM, Level flop and
// optional Rise/Fall pulse flops (SWITCH_DEBOUNCE_EDGE_EN).
module debounce_channel
   import switch_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic level,
   output logic rise,
   output logic fall
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   ,
   output logic flip
`endif
);

   localparam int            CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] TERM     = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

   logic          s1_r;
   logic          s2_r;
   logic [CW-1:0] cnt_r;
   logic          level_r;
   state_t        state_r;

   // Synchroniser plus stability FSM; Level flips only after TERM+1 mismatching edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r    <= 1'b0;
         s2_r    <= 1'b0;
         cnt_r   <= CNT_ZERO;
         level_r <= 1'b0;
         state_r <= STEADY;
      end else begin
         s1_r <= sw;
         s2_r <= s1_r;
         case (state_r)
            STEADY: begin
               if (s2_r == level_r) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= STEADY;
               end else if (TERM == CNT_ZERO) begin
                  level_r <= s2_r;
                  cnt_r   <= CNT_ZERO;
                  state_r <= STEADY;
               end else begin
                  cnt_r   <= CNT_ONE;
                  state_r <= PENDING;
               end
            end
            PENDING: begin
               if (s2_r == level_r) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= STEADY;
               end else if (cnt_r == TERM) begin
                  level_r <= s2_r;
                  cnt_r   <= CNT_ZERO;
                  state_r <= STEADY;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
                  state_r <= PENDING;
               end
            end
            default: begin
               cnt_r   <= CNT_ZERO;
               state_r <= STEADY;
            end
         endcase
      end
   end

   assign level = level_r;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
   logic flip_s;
   logic rise_r;
   logic fall_r;

   // Level is about to flip on this edge (STEADY always holds cnt at zero)
   always_comb begin
      flip_s = 1'b0;
      if ((s2_r != level_r) && (cnt_r == TERM)) begin
         flip_s = 1'b1;
      end else begin
         flip_s = 1'b0;
      end
   end

   // Pulse flops load together with the Level flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         rise_r <= flip_s & s2_r;
         fall_r <= flip_s & ~s2_r;
      end
   end

   assign rise = rise_r;
   assign fall = fall_r;
   assign flip = flip_s;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw switches into clean levels; with SWITCH_DEBOUNCE_EDGE_EN
// defined it also emits registered Rise/Fall pulses and a Changed summary pulse.
module switch_debouncer
   import switch_pkg::*;
#(
   parameter int WIDTH         = WIDTH_DEF,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
   input  logic             CLK,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] Switch,
   output logic [WIDTH-1:0] Level,
   output logic [WIDTH-1:0] Rise,
   output logic [WIDTH-1:0] Fall,
   output logic             Changed
);

   logic [WIDTH-1:0] level_s;
   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] flip_s;
   logic             changed_r;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk   (CLK),
         .rst_n (Rst_n),
         .sw    (Switch[i]),
         .level (level_s[i]),
         .rise  (rise_s[i]),
         .fall  (fall_s[i])
`ifdef SWITCH_DEBOUNCE_EDGE_EN
         ,
         .flip  (flip_s[i])
`endif
      );
   end

   assign Level = level_s;
   assign Rise  = rise_s;
   assign Fall  = fall_s;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
   // Registered from the pre-flop flip terms so it lines up with the pulses
   always_ff @(posedge CLK or negedge Rst_n) begin
      if (!Rst_n) begin
         changed_r <= 1'b0;
      end else begin
         changed_r <= |flip_s;
      end
   end

   assign Changed = changed_r;
`else
   assign Changed = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer; reference model is a sliding
// window over the recorded switch samples rather than a counter.
module tb_switch_debouncer;

   localparam int W  = 6;
   localparam int SC = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic         CLK;
   logic         Rst_n;
   logic [W-1:0] Switch;
   logic [W-1:0] Level;
   logic [W-1:0] Rise;
   logic [W-1:0] Fall;
   logic         Changed;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: hist[0] is the newest sampled Switch value
   logic [W-1:0] hist [0:SC];
   logic [W-1:0] m_level;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   logic         m_changed;
   logic [W-1:0] rise_seen;

   switch_debouncer #(
      .WIDTH        (W),
      .STABLE_CYCLES(SC)
   ) dut (
      .CLK    (CLK),
      .Rst_n  (Rst_n),
      .Switch (Switch),
      .Level  (Level),
      .Rise   (Rise),
      .Fall   (Fall),
      .Changed(Changed)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k <= SC; k++) hist[k] = '0;
      m_level   = '0;
      m_rise    = '0;
      m_fall    = '0;
      m_changed = 1'b0;
   endtask

   // A bit flips when the SC samples seen by the filter (skipping the newest,
   // still in the synchroniser) all disagree with the current level
   task automatic model_edge();
      logic [W-1:0] all_diff;
      if (!Rst_n) begin
         model_clear();
      end else begin
         all_diff = {W{1'b1}};
         for (int k = 1; k <= SC; k++) all_diff &= hist[k] ^ m_level;
         m_rise    = all_diff & ~m_level;
         m_fall    = all_diff & m_level;
         m_changed = |all_diff;
         m_level   = m_level ^ all_diff;
         for (int k = SC; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = Switch;
      end
   endtask

   task automatic compare_all();
      check_eq("level",   32'(Level),   32'(m_level));
      check_eq("rise",    32'(Rise),    EDGE_EN ? 32'(m_rise) : 32'd0);
      check_eq("fall",    32'(Fall),    EDGE_EN ? 32'(m_fall) : 32'd0);
      check_eq("changed", 32'(Changed), EDGE_EN ? 32'(m_changed) : 32'd0);
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      compare_all();
      rise_seen = rise_seen | Rise;
   endtask

   initial begin
      Rst_n     = 1'b0;
      Switch    = 6'h3F;
      rise_seen = '0;
      model_clear();
      #2;
      check_eq("rst_level",   32'(Level),   32'd0);
      check_eq("rst_rise",    32'(Rise),    32'd0);
      check_eq("rst_changed", 32'(Changed), 32'd0);
      repeat (3) step();

      // Reset release with all switches high: flip on the 6th edge
      Rst_n = 1'b1;
      repeat (5) step();
      check_eq("rr_level_e5", 32'(Level), 32'h00);
      step();
      check_eq("rr_level_e6",   32'(Level),   32'h3F);
      check_eq("rr_rise_e6",    32'(Rise),    EDGE_EN ? 32'h3F : 32'h00);
      check_eq("rr_changed_e6", 32'(Changed), EDGE_EN ? 32'd1 : 32'd0);
      step();
      check_eq("rr_rise_e7", 32'(Rise), 32'h00);

      // Falling edge on bit 5
      Switch = 6'h1F;
      repeat (6) step();
      check_eq("fall_level", 32'(Level), 32'h1F);
      check_eq("fall_pulse", 32'(Fall),  EDGE_EN ? 32'h20 : 32'h00);
      step();
      check_eq("fall_once",  32'(Fall),  32'h00);

      // Simultaneous rise on bit 1 and fall on bit 2
      Switch = 6'h04;
      repeat (10) step();
      check_eq("sim_pre_level", 32'(Level), 32'h04);
      Switch = 6'h02;
      repeat (6) step();
      check_eq("sim_level",   32'(Level),   32'h02);
      check_eq("sim_rise",    32'(Rise),    EDGE_EN ? 32'h02 : 32'h00);
      check_eq("sim_fall",    32'(Fall),    EDGE_EN ? 32'h04 : 32'h00);
      check_eq("sim_changed", 32'(Changed), EDGE_EN ? 32'd1 : 32'd0);
      step();
      check_eq("sim_changed_once", 32'(Changed), 32'd0);

      // Three-cycle glitch on bit 0 is rejected
      rise_seen = '0;
      Switch    = 6'h03;
      repeat (3) step();
      Switch = 6'h02;
      repeat (10) step();
      check_eq("glitch_level", 32'(Level),     32'h02);
      check_eq("glitch_rise",  32'(rise_seen), 32'h00);

      // Reset while bit 3 is pending
      Switch = 6'h0A;
      repeat (3) step();
      Rst_n = 1'b0;
      model_clear();
      #1;
      check_eq("mid_rst_level",   32'(Level),   32'h00);
      check_eq("mid_rst_rise",    32'(Rise),    32'h00);
      check_eq("mid_rst_changed", 32'(Changed), 32'd0);
      repeat (2) step();
      Rst_n = 1'b1;

      // Random phase: occasional new words, single-bit toggles and resets
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 199));
         if (r < 12) begin
            Switch = W'($urandom);
         end else if (r < 30) begin
            Switch[$urandom_range(0, W-1)] ^= 1'b1;
         end else if (r == 199) begin
            Rst_n = 1'b0;
            model_clear();
            #1;
            compare_all();
            step();
            Rst_n = 1'b1;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
